// File: rtl/tmr_mon_pkg.sv
// rtl/tmr_mon_pkg.sv - shared types and bundle layout for the NFC TMR fault monitor
package tmr_mon_pkg;

  localparam int NFC_BUNDLE_W = 27;
  localparam int NUM_REP      = 3;

  localparam int REP_A = 0;
  localparam int REP_B = 1;
  localparam int REP_C = 2;

  typedef enum logic [1:0] {
    REP_HEALTHY = 2'b00,
    REP_SUSPECT = 2'b01,
    REP_FAILED  = 2'b10
  } rep_state_t;

  // Bundle layout, MSB first: {done, IO_A, ctl_A, IO_B, ctl_B, reading_A, reading_B}
  localparam int BIT_READING_B = 0;
  localparam int BIT_READING_A = 1;
  localparam int LSB_CTL_B     = 2;
  localparam int LSB_IO_B      = 6;
  localparam int LSB_CTL_A     = 14;
  localparam int LSB_IO_A      = 18;
  localparam int BIT_DONE      = 26;

endpackage

// File: rtl/tmr_rep_health.sv
// rtl/tmr_rep_health.sv - one replica's HEALTHY/SUSPECT/FAILED tracker with run counters
// Optional lifetime mismatch counter enabled by TMR_MON_CNT_EN.
module tmr_rep_health
  import tmr_mon_pkg::*;
#(
  parameter int FAIL_TH  = 16,
  parameter int CLEAR_TH = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mismatch,
  input  logic             recover,
  output rep_state_t       state,
  output logic             enter_failed,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam logic [CNT_W-1:0] FAIL_LAST  = CNT_W'(FAIL_TH - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TH - 1);

  rep_state_t       state_q, state_d;
  logic [CNT_W-1:0] mis_run_q, mis_run_d;
  logic [CNT_W-1:0] match_run_q, match_run_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= REP_HEALTHY;
      mis_run_q   <= '0;
      match_run_q <= '0;
    end else begin
      state_q     <= state_d;
      mis_run_q   <= mis_run_d;
      match_run_q <= match_run_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mis_run_d   = mis_run_q;
    match_run_d = match_run_q;
    case (state_q)
      REP_HEALTHY: begin
        if (mismatch) begin
          state_d     = REP_SUSPECT;
          mis_run_d   = CNT_W'(1);
          match_run_d = '0;
        end
      end
      REP_SUSPECT: begin
        if (mismatch) begin
          if (mis_run_q == FAIL_LAST) begin
            state_d     = REP_FAILED;
            mis_run_d   = '0;
            match_run_d = '0;
          end else begin
            mis_run_d   = mis_run_q + CNT_W'(1);
            match_run_d = '0;
          end
        end else begin
          if (match_run_q == CLEAR_LAST) begin
            state_d     = REP_HEALTHY;
            mis_run_d   = '0;
            match_run_d = '0;
          end else begin
            match_run_d = match_run_q + CNT_W'(1);
            mis_run_d   = '0;
          end
        end
      end
      REP_FAILED: begin
        if (recover) begin
          state_d     = REP_SUSPECT;
          mis_run_d   = '0;
          match_run_d = '0;
        end
      end
      default: begin
        state_d     = REP_HEALTHY;
        mis_run_d   = '0;
        match_run_d = '0;
      end
    endcase
  end

  assign state        = state_q;
  assign enter_failed = (state_q != REP_FAILED) && (state_d == REP_FAILED);

`ifdef TMR_MON_CNT_EN
  logic [CNT_W-1:0] mis_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_cnt_q <= '0;
    end else if (mismatch && (mis_cnt_q != '1)) begin
      mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign mis_cnt = mis_cnt_q;
`else
  assign mis_cnt = '0;
`endif

endmodule

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - degradable TMR voter with per-replica health and fault reporting
// Build option TMR_MON_CNT_EN enables the per-replica mismatch totals.
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int W        = NFC_BUNDLE_W,
  parameter int FAIL_TH  = 16,
  parameter int CLEAR_TH = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     data_A,
  input  logic [W-1:0]     data_B,
  input  logic [W-1:0]     data_C,
  input  logic             recover,
  input  logic             fault_ack,
  output logic [W-1:0]     data_out,
  output logic             tmr_error,
  output logic             double_fault,
  output logic [5:0]       rep_state,
  output logic             fault_vld,
  output logic [1:0]       fault_rep,
  output logic [W-1:0]     fault_mask,
  output logic [CNT_W-1:0] mis_cnt_A,
  output logic [CNT_W-1:0] mis_cnt_B,
  output logic [CNT_W-1:0] mis_cnt_C
);

  logic [W-1:0]       data [NUM_REP];
  rep_state_t         st [NUM_REP];
  logic [CNT_W-1:0]   mis_cnt [NUM_REP];
  logic [W-1:0]       mask_q [NUM_REP];
  logic [NUM_REP-1:0] active, mismatch, enter_failed;
  logic [NUM_REP-1:0] pend_q, pend_d;
  logic [W-1:0]       last_good_q;
  logic               double_cond;
  logic               ack_fire;

  assign data[REP_A] = data_A;
  assign data[REP_B] = data_B;
  assign data[REP_C] = data_C;

  for (genvar i = 0; i < NUM_REP; i++) begin : g_rep
    assign active[i]   = (st[i] != REP_FAILED);
    assign mismatch[i] = active[i] && (data[i] != data_out);

    tmr_rep_health #(
      .FAIL_TH  (FAIL_TH),
      .CLEAR_TH (CLEAR_TH),
      .CNT_W    (CNT_W)
    ) u_health (
      .clk          (clk),
      .rst          (rst),
      .mismatch     (mismatch[i]),
      .recover      (recover),
      .state        (st[i]),
      .enter_failed (enter_failed[i]),
      .mis_cnt      (mis_cnt[i])
    );
  end

  // No agreeing pair among the active replicas falls back to last_good.
  always_comb begin
    data_out    = last_good_q;
    double_cond = 1'b1;
    case (active)
      3'b111: begin
        data_out    = (data_A & data_B) | (data_A & data_C) | (data_B & data_C);
        double_cond = (data_A != data_B) && (data_A != data_C) && (data_B != data_C);
      end
      3'b011: if (data_A == data_B) begin data_out = data_A; double_cond = 1'b0; end
      3'b101: if (data_A == data_C) begin data_out = data_A; double_cond = 1'b0; end
      3'b110: if (data_B == data_C) begin data_out = data_B; double_cond = 1'b0; end
      3'b001: data_out = data_A;
      3'b010: data_out = data_B;
      3'b100: data_out = data_C;
      default: ;
    endcase
  end

  always_comb begin
    fault_rep  = 2'd0;
    fault_mask = '0;
    if (pend_q[REP_A]) begin
      fault_rep  = 2'(REP_A);
      fault_mask = mask_q[REP_A];
    end else if (pend_q[REP_B]) begin
      fault_rep  = 2'(REP_B);
      fault_mask = mask_q[REP_B];
    end else if (pend_q[REP_C]) begin
      fault_rep  = 2'(REP_C);
      fault_mask = mask_q[REP_C];
    end
  end

  assign fault_vld = |pend_q;
  assign ack_fire  = fault_vld && fault_ack;

  // A fresh failure of the acked index overrides the ack clear.
  always_comb begin
    pend_d = pend_q;
    if (ack_fire) pend_d[fault_rep] = 1'b0;
    pend_d = pend_d | enter_failed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q       <= '0;
      last_good_q  <= '0;
      tmr_error    <= 1'b0;
      double_fault <= 1'b0;
      for (int i = 0; i < NUM_REP; i++) mask_q[i] <= '0;
    end else begin
      pend_q       <= pend_d;
      tmr_error    <= |mismatch;
      double_fault <= double_cond;
      if (!double_cond) last_good_q <= data_out;
      for (int i = 0; i < NUM_REP; i++) begin
        if (enter_failed[i]) mask_q[i] <= data[i] ^ data_out;
      end
    end
  end

  assign rep_state = {st[REP_C], st[REP_B], st[REP_A]};
  assign mis_cnt_A = mis_cnt[REP_A];
  assign mis_cnt_B = mis_cnt[REP_B];
  assign mis_cnt_C = mis_cnt[REP_C];

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - directed self-checking bench for tmr_fault_monitor
module tb_tmr_fault_monitor;

  localparam logic [26:0] V  = 27'h155AA01;
  localparam logic [26:0] V2 = 27'h0ABCDEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] data_A, data_B, data_C;
  logic        recover, fault_ack;
  logic [26:0] data_out;
  logic        tmr_error, double_fault;
  logic [5:0]  rep_state;
  logic        fault_vld;
  logic [1:0]  fault_rep;
  logic [26:0] fault_mask;
  logic [7:0]  mis_cnt_A, mis_cnt_B, mis_cnt_C;

  int errors = 0;
  int checks = 0;
  logic seen_vld;
  logic [31:0] cnt_exp;

  tmr_fault_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .data_A       (data_A),
    .data_B       (data_B),
    .data_C       (data_C),
    .recover      (recover),
    .fault_ack    (fault_ack),
    .data_out     (data_out),
    .tmr_error    (tmr_error),
    .double_fault (double_fault),
    .rep_state    (rep_state),
    .fault_vld    (fault_vld),
    .fault_rep    (fault_rep),
    .fault_mask   (fault_mask),
    .mis_cnt_A    (mis_cnt_A),
    .mis_cnt_B    (mis_cnt_B),
    .mis_cnt_C    (mis_cnt_C)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; recover = 1'b0; fault_ack = 1'b0;
    data_A = V; data_B = V; data_C = V;
    #1;
    chk("rst_state", 32'(rep_state), 32'h0);
    chk("rst_vld", 32'(fault_vld), 32'h0);
    chk("rst_err", 32'(tmr_error), 32'h0);
    chk("rst_dbl", 32'(double_fault), 32'h0);
    chk("rst_out", 32'(data_out), 32'(V));
    chk("rst_cnt", 32'(mis_cnt_B), 32'h0);
    @(negedge clk) rst = 1'b1;

    // 1: all equal
    tick(100);
    chk("t1_out", 32'(data_out), 32'(V));
    chk("t1_err", 32'(tmr_error), 32'h0);
    chk("t1_state", 32'(rep_state), 32'h0);

    // 3: short glitch on B recovers without a report
    seen_vld = 1'b0;
    data_B = V ^ 27'h8;
    for (int i = 0; i < 5; i++) begin tick(1); seen_vld |= fault_vld; end
    chk("t3_suspect", 32'(rep_state), 32'h04);
    data_B = V;
    for (int i = 0; i < 7; i++) begin tick(1); seen_vld |= fault_vld; end
    chk("t3_still_suspect", 32'(rep_state), 32'h04);
    tick(1); seen_vld |= fault_vld;
    chk("t3_healthy", 32'(rep_state), 32'h00);
    chk("t3_no_vld", 32'(seen_vld), 32'h0);

    // 2: B bit3 stuck for 16 cycles
    data_B = V ^ 27'h8;
    #1;
    chk("t2_out_comb", 32'(data_out), 32'(V));
    tick(1);
    chk("t2_suspect", 32'(rep_state), 32'h04);
    chk("t2_err", 32'(tmr_error), 32'h1);
    tick(14);
    chk("t2_15_state", 32'(rep_state), 32'h04);
    chk("t2_15_vld", 32'(fault_vld), 32'h0);
    tick(1);
    chk("t2_failed", 32'(rep_state), 32'h08);
    chk("t2_vld", 32'(fault_vld), 32'h1);
    chk("t2_rep", 32'(fault_rep), 32'h1);
    chk("t2_mask", 32'(fault_mask), 32'h8);
    chk("t2_out", 32'(data_out), 32'(V));
    tick(1);
    chk("t2_err_clr", 32'(tmr_error), 32'h0);
    chk("t2_dbl", 32'(double_fault), 32'h0);

    // 5: two active replicas disagree -> last_good held
    data_A = V2; data_C = V2;
    tick(1);
    data_A = 27'h1111111; data_C = 27'h2222222;
    #1;
    chk("t5_hold_comb", 32'(data_out), 32'(V2));
    tick(1);
    chk("t5_dbl", 32'(double_fault), 32'h1);
    chk("t5_err", 32'(tmr_error), 32'h1);
    chk("t5_hold", 32'(data_out), 32'(V2));
    recover = 1'b1;
    tick(1);
    recover = 1'b0;
    chk("t5_recover", 32'(rep_state), 32'h15);
    chk("t5_keep_vld", 32'(fault_vld), 32'h1);
    chk("t5_keep_rep", 32'(fault_rep), 32'h1);
    chk("t5_keep_mask", 32'(fault_mask), 32'h8);
    fault_ack = 1'b1;
    tick(1);
    fault_ack = 1'b0;
    chk("t5_ack", 32'(fault_vld), 32'h0);
    data_A = V; data_B = V; data_C = V;
    tick(8);
    chk("t5_all_healthy", 32'(rep_state), 32'h00);

    // 4: A and C fail on the same edge
    data_A = V ^ 27'h1; data_C = V ^ 27'h2;
    tick(15);
    chk("t4_pre_vld", 32'(fault_vld), 32'h0);
    tick(1);
    chk("t4_state", 32'(rep_state), 32'h22);
    chk("t4_vld", 32'(fault_vld), 32'h1);
    chk("t4_rep0", 32'(fault_rep), 32'h0);
    chk("t4_mask0", 32'(fault_mask), 32'h1);
    fault_ack = 1'b1;
    tick(1);
    fault_ack = 1'b0;
    chk("t4_vld2", 32'(fault_vld), 32'h1);
    chk("t4_rep2", 32'(fault_rep), 32'h2);
    chk("t4_mask2", 32'(fault_mask), 32'h2);
    chk("t4_dbl", 32'(double_fault), 32'h1);
    chk("t4_out", 32'(data_out), 32'(V));
    data_B = 27'h7FFFFFF;
    #1;
    chk("t4_single", 32'(data_out), 32'h7FFFFFF);

    // 6: async reset while A and C are SUSPECT and rep 2 is still pending
    recover = 1'b1;
    tick(1);
    recover = 1'b0;
    chk("t6_suspect", 32'(rep_state), 32'h11);
    data_A = V; data_B = V; data_C = V;
    #2 rst = 1'b0;
    #1;
    chk("t6_state", 32'(rep_state), 32'h0);
    chk("t6_vld", 32'(fault_vld), 32'h0);
    chk("t6_mask", 32'(fault_mask), 32'h0);
    chk("t6_dbl", 32'(double_fault), 32'h0);
    chk("t6_err", 32'(tmr_error), 32'h0);
    chk("t6_out", 32'(data_out), 32'(V));
    @(negedge clk) rst = 1'b1;

    // mismatch totals: B keeps failing and being recovered
    recover = 1'b1;
    data_B = V ^ 27'h8;
    tick(400);
    recover = 1'b0;
`ifdef TMR_MON_CNT_EN
    cnt_exp = 32'd255;
`else
    cnt_exp = 32'd0;
`endif
    chk("cnt_B", 32'(mis_cnt_B), cnt_exp);
    chk("cnt_A", 32'(mis_cnt_A), 32'h0);
    chk("cnt_out", 32'(data_out), 32'(V));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
